// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: I-cache request/response plus decode-side handshake.
// The fetch stage uses the master modport; the cache/decode environment uses slave.
interface fetch_prefetch_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            cache_ack;
  logic [XLEN-1:0] inst;
  logic            addr_ready;
  logic [XLEN-1:0] addr;
  logic            stall;
  logic            jal;
  logic            branch;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] b_target;
  logic [XLEN-1:0] final_pc;
  logic [XLEN-1:0] final_inst;
  logic            final_valid;
  logic [CW-1:0]   q_count;

  modport master (
    input  cache_ack, inst, stall, jal, branch, j_target, b_target,
    output addr_ready, addr, final_pc, final_inst, final_valid, q_count
  );

  modport slave (
    output cache_ack, inst, stall, jal, branch, j_target, b_target,
    input  addr_ready, addr, final_pc, final_inst, final_valid, q_count
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage: one outstanding I-cache request, DEPTH-entry prefetch queue,
// redirect flush, and an epoch (stale) state that drops responses to pre-redirect requests.
module fetch_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input logic             clk,
  input logic             rst,
  fetch_prefetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT       = 2'd1;
  localparam logic [1:0] S_WAIT_STALE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];
  logic [XLEN-1:0] inst_mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] final_pc_q, final_pc_d;
  logic [XLEN-1:0] final_inst_q, final_inst_d;
  logic            final_valid_q, final_valid_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            issue;
  logic            push;
  logic            pop;

  always_comb begin
    redirect = bus.jal | bus.branch;
    target   = bus.jal ? bus.j_target : bus.b_target;
    issue    = !rst && (state_q == S_IDLE) && !redirect && (count_q < FULL);
    // A response is kept unless its epoch is stale or a redirect lands with it.
    push     = bus.cache_ack && (state_q != S_WAIT_STALE) && !redirect;
    pop      = !redirect && !bus.stall && (count_q != '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cache_ack) state_d = S_IDLE;
        else if (redirect) state_d = S_WAIT_STALE;
      end
      S_WAIT_STALE: begin
        if (bus.cache_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      fpc_d = target;
    end else if (issue) begin
      fpc_d    = fpc_q + XLEN'(4);
      req_pc_d = fpc_q;
    end
  end

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]   = req_pc_q;
        inst_mem_d[tail_q] = bus.inst;
        tail_d             = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    final_pc_d    = final_pc_q;
    final_inst_d  = NOP;
    final_valid_d = 1'b0;
    if (pop) begin
      final_pc_d    = pc_mem_q[head_q];
      final_inst_d  = inst_mem_q[head_q];
      final_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
    if (rst) begin
      state_q       <= S_IDLE;
      fpc_q         <= RESET_PC;
      req_pc_q      <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      final_pc_q    <= RESET_PC - XLEN'(4);
      final_inst_q  <= NOP;
      final_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      req_pc_q      <= req_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      final_pc_q    <= final_pc_d;
      final_inst_q  <= final_inst_d;
      final_valid_q <= final_valid_d;
    end
  end

  assign bus.addr_ready  = issue;
  assign bus.addr        = fpc_q;
  assign bus.final_pc    = final_pc_q;
  assign bus.final_inst  = final_inst_q;
  assign bus.final_valid = final_valid_q;
  assign bus.q_count     = count_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: cache responder with programmable latency,
// expected decode stream in a scoreboard queue, separate monitor comparing on final_valid.
module tb_fetch_prefetch;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] RPC_M4 = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  bit   sb_open;
  exp_t sb_q[$];

  fetch_prefetch_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_prefetch #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h00A0_5000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_of(pc);
    sb_q.push_back(e);
  endtask

  // Cache model: one ack exactly lat cycles after the request cycle.
  initial begin : responder
    bit          pend;
    int          wait_n;
    logic [31:0] paddr;
    pend = 0;
    wait_n = 0;
    paddr = '0;
    bus.cache_ack = 1'b0;
    bus.inst = '0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (bus.addr_ready) begin
        pend = 1;
        paddr = bus.addr;
        wait_n = lat;
      end
      @(posedge clk);
      #1;
      bus.cache_ack = 1'b0;
      if (pend) begin
        if (wait_n <= 1) begin
          bus.cache_ack = 1'b1;
          bus.inst = inst_of(paddr);
          pend = 0;
        end else begin
          wait_n--;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.final_valid) begin
          if (sb_open) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL dec_unexpected got_pc=%h exp=none", bus.final_pc);
            end else begin
              e = sb_q.pop_front();
              chk("dec_pc", bus.final_pc, e.pc);
              chk("dec_inst", bus.final_inst, e.inst);
            end
          end
        end else begin
          chk("bubble_nop", bus.final_inst, NOP_I);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.jal = 1'b0;
    bus.branch = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.addr_ready && n < 50);
    if (!bus.addr_ready) begin
      checks++;
      failures++;
      $display("FAIL req_timeout got=none exp=%h", exp);
    end else begin
      chk("req_addr", bus.addr, exp);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain remaining=%0d exp=0", sb_q.size());
    end
    sb_open = 0;
    sb_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    checks = 0;
    failures = 0;
    sb_open = 0;
    lat = 1;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.jal = 1'b0;
    bus.branch = 1'b0;
    bus.j_target = '0;
    bus.b_target = '0;

    // Test 1: free-running fetch, ack one cycle after each request
    lat = 1;
    bus.stall = 1'b0;
    for (int unsigned i = 0; i < 5; i++) exp_push(32'(i * 4));
    do_reset();
    sb_open = 1;
    @(negedge clk);
    chk("rst_q_count", 32'(bus.q_count), 32'd0);
    chk("rst_final_valid", 32'(bus.final_valid), 32'd0);
    chk("rst_final_pc", bus.final_pc, RPC_M4);
    chk("rst_final_inst", bus.final_inst, NOP_I);
    chk("rst_addr_ready", 32'(bus.addr_ready), 32'd1);
    chk("rst_addr", bus.addr, 32'h0);
    for (int unsigned i = 1; i < 5; i++) wait_req(32'(i * 4));
    wait_drain();

    // Test 2: ten stall cycles fill the queue, release drains back-to-back
    bus.stall = 1'b1;
    for (int unsigned i = 0; i < 4; i++) exp_push(32'(i * 4));
    do_reset();
    sb_open = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("full_q_count", 32'(bus.q_count), 32'd4);
    chk("full_addr_ready", 32'(bus.addr_ready), 32'd0);
    @(negedge clk);
    chk("full_q_count2", 32'(bus.q_count), 32'd4);
    chk("full_addr_ready2", 32'(bus.addr_ready), 32'd0);
    chk("stall_final_pc", bus.final_pc, RPC_M4);
    chk("stall_final_valid", 32'(bus.final_valid), 32'd0);
    step();
    bus.stall = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_consecutive", 32'(bus.final_valid), 32'd1);
    end
    wait_drain();

    // Test 3: jal while request to 0x8 outstanding; that ack must be dropped
    lat = 3;
    bus.stall = 1'b0;
    exp_push(32'h0);
    exp_push(32'h4);
    exp_push(32'h100);
    exp_push(32'h104);
    do_reset();
    sb_open = 1;
    wait_req(32'h0);
    wait_req(32'h4);
    wait_req(32'h8);
    step();
    bus.jal = 1'b1;
    bus.j_target = 32'h100;
    step();
    bus.jal = 1'b0;
    @(negedge clk);
    chk("stale_no_req1", 32'(bus.addr_ready), 32'd0);
    @(negedge clk);
    chk("stale_no_req2", 32'(bus.addr_ready), 32'd0);
    @(negedge clk);
    chk("post_stale_req", 32'(bus.addr_ready), 32'd1);
    chk("post_stale_addr", bus.addr, 32'h100);
    wait_drain();

    // Test 4: jal and branch together, queue holding entries; jal wins, queue flushed
    lat = 1;
    bus.stall = 1'b1;
    exp_push(32'h200);
    exp_push(32'h204);
    do_reset();
    sb_open = 1;
    wait_req(32'h0);
    wait_req(32'h4);
    wait_req(32'h8);
    step();
    bus.jal = 1'b1;
    bus.branch = 1'b1;
    bus.j_target = 32'h200;
    bus.b_target = 32'h300;
    step();
    bus.jal = 1'b0;
    bus.branch = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    chk("flush_q_count", 32'(bus.q_count), 32'd0);
    chk("jal_prio_req", 32'(bus.addr_ready), 32'd1);
    chk("jal_prio_addr", bus.addr, 32'h200);
    wait_drain();

    // Test 5: branch coinciding with cache_ack: response dropped, no stale epoch
    lat = 2;
    bus.stall = 1'b0;
    exp_push(32'h0);
    exp_push(32'h40);
    exp_push(32'h44);
    do_reset();
    sb_open = 1;
    wait_req(32'h0);
    wait_req(32'h4);
    step();
    step();
    bus.branch = 1'b1;
    bus.b_target = 32'h40;
    step();
    bus.branch = 1'b0;
    @(negedge clk);
    chk("br_ack_req", 32'(bus.addr_ready), 32'd1);
    chk("br_ack_addr", bus.addr, 32'h40);
    wait_drain();

    // Test 6: reset with three queued entries and the ack landing in the reset cycle
    lat = 3;
    bus.stall = 1'b1;
    do_reset();
    wait_req(32'h0);
    wait_req(32'h4);
    wait_req(32'h8);
    wait_req(32'hC);
    chk("pre_rst_q_count", 32'(bus.q_count), 32'd3);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_q_count", 32'(bus.q_count), 32'd0);
    chk("rst2_final_valid", 32'(bus.final_valid), 32'd0);
    chk("rst2_final_pc", bus.final_pc, RPC_M4);
    chk("rst2_addr_ready", 32'(bus.addr_ready), 32'd1);
    chk("rst2_addr", bus.addr, 32'h0);
    exp_push(32'h0);
    exp_push(32'h4);
    sb_open = 1;
    step();
    bus.stall = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
